// File: rtl/ex_muldiv_ctrl.sv
// EX-stage sequencer for the multi-cycle multiplier and iterative divider.
// Optional result reuse cache enabled by defining MULDIV_REUSE_EN.
`ifndef OP_MUL
`define OP_MUL   8'h1c
`define OP_MULH  8'h1d
`define OP_MULHU 8'h1e
`define OP_DIV   8'h20
`define OP_MOD   8'h21
`define OP_DIVU  8'h22
`define OP_MODU  8'h23
`endif

module ex_muldiv_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_op,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result,
    output logic              div_start,
    output logic              div_cancel,
    output logic [OP_W-1:0]   div_op,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic              div_done,
    input  logic [DATA_W-1:0] div_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_DRAIN, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              short_q, short_d;
    logic [DATA_W-1:0] short_res_q, short_res_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              mul_start_q, mul_start_d;
    logic              div_start_q, div_start_d;
    logic              div_cancel_q, div_cancel_d;

    logic              accept_c, is_mul_c, is_div_c, is_mod_c;
    logic              hit_c;
    logic [DATA_W-1:0] hit_res_c;

    assign req_ready = (state_q == S_IDLE) & ~flush & ~rst;
    assign accept_c  = req_valid & req_ready;

    assign is_mul_c = (req_op == OP_W'(`OP_MUL)) | (req_op == OP_W'(`OP_MULH)) |
                      (req_op == OP_W'(`OP_MULHU));
    assign is_mod_c = (req_op == OP_W'(`OP_MOD)) | (req_op == OP_W'(`OP_MODU));
    assign is_div_c = is_mod_c | (req_op == OP_W'(`OP_DIV)) | (req_op == OP_W'(`OP_DIVU));

    // Zero-divisor results and cache hits park one cycle in DIV_WAIT (short_q)
    // so every local result behaves like a unit with zero latency.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        short_d      = short_q;
        short_res_d  = short_res_q;
        res_data_d   = res_data_q;
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    short_d = 1'b0;
                    if ((is_mul_c | is_div_c) & hit_c) begin
                        state_d     = S_DIV_WAIT;
                        short_d     = 1'b1;
                        short_res_d = hit_res_c;
                    end else if (is_mul_c) begin
                        state_d     = S_MUL_WAIT;
                        mul_start_d = 1'b1;
                    end else if (is_div_c && req_b == '0) begin
                        state_d     = S_DIV_WAIT;
                        short_d     = 1'b1;
                        short_res_d = is_mod_c ? req_a : '0;
                    end else if (is_div_c) begin
                        state_d     = S_DIV_WAIT;
                        div_start_d = 1'b1;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (flush) begin
                    state_d = mul_done ? S_IDLE : S_DRAIN;
                end else if (mul_done) begin
                    state_d    = S_DONE;
                    res_data_d = mul_result;
                end
            end
            S_DIV_WAIT: begin
                if (flush) begin
                    state_d      = S_IDLE;
                    div_cancel_d = ~short_q;
                end else if (short_q) begin
                    state_d    = S_DONE;
                    res_data_d = short_res_q;
                end else if (div_done) begin
                    state_d    = S_DONE;
                    res_data_d = div_result;
                end
            end
            S_DRAIN: begin
                if (mul_done) state_d = S_IDLE;
            end
            S_DONE: begin
                if (flush | res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            short_q      <= 1'b0;
            short_res_q  <= '0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            short_q      <= short_d;
            short_res_q  <= short_res_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
        end
    end

`ifdef MULDIV_REUSE_EN
    logic              cache_vld_q, cache_vld_d;
    logic [OP_W-1:0]   cache_op_q, cache_op_d;
    logic [DATA_W-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [DATA_W-1:0] cache_res_q, cache_res_d;

    assign hit_c     = cache_vld_q & (cache_op_q == req_op) &
                       (cache_a_q == req_a) & (cache_b_q == req_b);
    assign hit_res_c = cache_res_q;

    // Every non-flushed entry into DONE refreshes the cache with the in-flight op.
    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_op_d  = cache_op_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_res_d = cache_res_q;
        if (state_d == S_DONE && state_q != S_DONE) begin
            cache_vld_d = 1'b1;
            cache_op_d  = op_q;
            cache_a_d   = a_q;
            cache_b_d   = b_q;
            cache_res_d = res_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_op_q  <= '0;
            cache_a_q   <= '0;
            cache_b_q   <= '0;
            cache_res_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_op_q  <= cache_op_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_res_q <= cache_res_d;
        end
    end
`else
    assign hit_c     = 1'b0;
    assign hit_res_c = '0;
`endif

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign busy       = busy_q;
    assign mul_start  = mul_start_q;
    assign div_start  = div_start_q;
    assign div_cancel = div_cancel_q;
    assign mul_op     = op_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign div_op     = op_q;
    assign div_a      = a_q;
    assign div_b      = b_q;

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
EX-stage sequencer for the long-latency integer units: the multi-cycle multiplier and the iterative divider. It accepts one MUL/MULH/MULHU/DIV/DIVU/MOD/MODU request from the EX pipeline, launches the correct unit, and waits for its done signal. It then holds the 32-bit result until writeback takes it. It also owns flush handling, the divide-by-zero short-circuit, and pipeline back-pressure (req_ready) while a unit is busy.

Parameters:
DATA_W, 32, operand/result width
OP_W, 8, op code width (op codes are the `OP_* defines from defs.v)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  EX presents a request
req_ready  out  1  controller can accept
req_op  in  OP_W  op code
req_a  in  DATA_W  operand rj
req_b  in  DATA_W  operand rk
flush  in  1  pipeline flush; kill in-flight op
res_valid  out  1  result available
res_ready  in  1  writeback consumes result
res_data  out  DATA_W  result
busy  out  1  state != IDLE
mul_start  out  1  one-cycle launch pulse to multiplier
mul_op  out  OP_W  latched op to multiplier
mul_a, mul_b  out  DATA_W  latched operands to multiplier
mul_done  in  1  multiplier result valid (one cycle)
mul_result  in  DATA_W  multiplier result
div_start  out  1  one-cycle launch pulse to divider
div_cancel  out  1  one-cycle abort pulse to divider
div_op  out  OP_W  latched op to divider
div_a, div_b  out  DATA_W  latched operands to divider
div_done  in  1  divider result valid (one cycle)
div_result  in  DATA_W  divider result

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - All outputs 0, except req_ready=1 once rst is deasserted.
  - Latched op/operands cleared.
  - Reset mid-operation returns to IDLE with no div_cancel and no result.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN, DONE.
- req_ready = (state==IDLE) & ~flush. Accept = req_valid & req_ready.
- IDLE, accept:
  - Latch op/a/b; mul_*/div_* operand outputs come from these registers.
  - MUL-class op: mul_start=1 the next cycle; state -> MUL_WAIT.
  - DIV-class op with b!=0: div_start=1 the next cycle; state -> DIV_WAIT.
  - DIV-class op with b==0: no launch. DIV/DIVU -> res_data=0; MOD/MODU -> res_data=a. State -> DONE next cycle.
  - Non-muldiv op: accepted and dropped; state stays IDLE.
- MUL_WAIT:
  - On mul_done: capture mul_result, go to DONE. res_valid rises the cycle after mul_done.
  - Latency, accept to res_valid: multiplier latency + 2.
- DIV_WAIT: on div_done, capture div_result and go to DONE (same timing as MUL_WAIT).
- DONE:
  - res_valid=1; res_data stable until res_valid & res_ready.
  - On handshake: IDLE next cycle. No new request is accepted in the same cycle.
- flush (highest priority over every other event):
  - IDLE: request ignored.
  - MUL_WAIT without mul_done: go to DRAIN. The multiplier cannot be aborted.
  - MUL_WAIT with mul_done in the same cycle: result discarded, IDLE.
  - DIV_WAIT: div_cancel=1 for one cycle, IDLE next cycle. A div_done in the same cycle is discarded.
  - DONE: result dropped, res_valid=0 next cycle, IDLE.
  - DRAIN: no effect.
- DRAIN: wait for mul_done, discard it, go to IDLE. req_ready=0 throughout.
- mul_start/div_start: exactly one pulse per launch; never both in one cycle.
- mul_done/div_done arriving in any state other than its WAIT/DRAIN state: ignored.

Optional Feature:
Macro MULDIV_REUSE_EN.
- Defined: a result cache holds {valid, op, a, b, result}, loaded at every DONE entry from a unit or the div-by-zero path.
  - An accepted request whose op, a and b all match a valid entry launches nothing and enters DONE next cycle with the cached result (latency 2).
  - Cache invalidated on rst only. A flushed op never loads the cache.
- Undefined: no cache; every op launches its unit (or takes the zero-divisor path).

Test Plan:
- MUL a=0x00000003, b=0xFFFFFFFE; stub returns mul_done with 0xFFFFFFFA 3 cycles after mul_start -> one mul_start pulse; res_valid=1 one cycle after mul_done; res_data=0xFFFFFFFA; req_ready=0 until handshake.
- DIV a=7, b=0 -> no div_start; res_data=0 two cycles after accept. MODU a=7, b=0 -> res_data=0x00000007.
- MULH accepted; flush 1 cycle after mul_start; mul_done 2 cycles later -> state DRAIN; no res_valid; req_ready returns 1 the cycle after mul_done.
- DIVU a=100, b=7; flush 3 cycles after div_start -> exactly one div_cancel pulse; req_ready=1 next cycle; a late div_done is ignored.
- MUL completes; res_ready held 0 for 5 cycles -> res_valid and res_data stable all 5 cycles; busy=1; second req_valid not accepted until the cycle after the handshake.
- MULDIV_REUSE_EN: MUL a=5, b=6 (result 30), then identical MUL -> second op issues no mul_start; res_data=30 two cycles after accept. A following MULH with the same operands does launch the multiplier.
